// File: rtl/mem_weight_bank_mc.sv
// mem_weight_bank_mc
// Multi-bank signed weight store for the class-sum stage. All banks share one
// row address so a single read returns the whole per-class weight vector.
// SPI configuration writes target one bank/row and always win over reads; a
// read that collides with a write is parked in a one-entry pending buffer and
// issued on the first write-free cycle.
module mem_weight_bank_mc #(
    parameter int NUM_BANKS      = 4,
    parameter int DEPTH          = 2048,
    parameter int WEIGHT_WIDTH   = 9,
    parameter int SPI_ADDR_WIDTH = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              rd_req,
    input  logic [$clog2(DEPTH)-1:0]          rd_addr,
    output logic                              rd_busy,
    output logic                              rd_valid,
    output logic [NUM_BANKS*WEIGHT_WIDTH-1:0] rd_data,
    input  logic                              spi_wen_sync,
    input  logic [SPI_ADDR_WIDTH-1:0]         SPI_ADDR,
    input  logic [31:0]                       SPI_DATA,
    output logic                              wr_err,
    input  logic                              err_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int DW = NUM_BANKS * WEIGHT_WIDTH;

    // IDLE: no read parked; PEND: a collided read waits for a write-free cycle
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   pend_addr_q, pend_addr_d;
    logic            rd_valid_q, rd_valid_d;
    logic [DW-1:0]   rd_data_q, rd_data_d;
    logic            wr_err_q, wr_err_d;

    logic [AW-1:0]   spi_row_s;
    logic [BW-1:0]   spi_bank_s;
    logic            bank_ok_s;
    logic            wr_en_s;
    logic            rd_issue_s;
    logic [AW-1:0]   rd_issue_addr_s;
    logic [DW-1:0]   rd_word_s;

    // Address fields above the bank field are deliberately ignored
    assign spi_row_s  = SPI_ADDR[AW-1:0];
    assign spi_bank_s = SPI_ADDR[AW +: BW];
    assign bank_ok_s  = (32'(spi_bank_s) < 32'(NUM_BANKS));
    assign wr_en_s    = spi_wen_sync & bank_ok_s;

    if (WEIGHT_WIDTH < 32) begin : g_data_unused
        logic unused_data_s;
        assign unused_data_s = ^SPI_DATA[31:WEIGHT_WIDTH];
    end

    if (SPI_ADDR_WIDTH > AW + BW) begin : g_addr_unused
        logic unused_addr_s;
        assign unused_addr_s = ^SPI_ADDR[SPI_ADDR_WIDTH-1:AW+BW];
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [WEIGHT_WIDTH-1:0] mem [DEPTH];

        // Write port: only the addressed bank takes the SPI word; no reset on storage
        always_ff @(posedge clk) begin
            if (wr_en_s && (spi_bank_s == BW'(b))) begin
                mem[spi_row_s] <= SPI_DATA[WEIGHT_WIDTH-1:0];
            end
        end

        assign rd_word_s[b*WEIGHT_WIDTH +: WEIGHT_WIDTH] = mem[rd_issue_addr_s];
    end

    // Next-state logic: decide whether a read issues this cycle or gets parked
    always_comb begin
        state_d         = state_q;
        pend_addr_d     = pend_addr_q;
        rd_issue_s      = 1'b0;
        rd_issue_addr_s = rd_addr;
        case (state_q)
            ST_IDLE: begin
                if (spi_wen_sync) begin
                    if (rd_req) begin
                        state_d     = ST_PEND;
                        pend_addr_d = rd_addr;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    rd_issue_s = rd_req;
                end
            end
            ST_PEND: begin
                // New requests are ignored while a read is parked
                rd_issue_addr_s = pend_addr_q;
                if (!spi_wen_sync) begin
                    rd_issue_s = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    state_d = ST_PEND;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output datapath and sticky error flag; a bad write beats a clear
    always_comb begin
        rd_valid_d = rd_issue_s;
        if (rd_issue_s) begin
            rd_data_d = rd_word_s;
        end else begin
            rd_data_d = rd_data_q;
        end
        if (spi_wen_sync && !bank_ok_s) begin
            wr_err_d = 1'b1;
        end else if (err_clr) begin
            wr_err_d = 1'b0;
        end else begin
            wr_err_d = wr_err_q;
        end
    end

    // Control and output registers; reset drops any parked read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pend_addr_q <= '0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            wr_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_addr_q <= pend_addr_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            wr_err_q    <= wr_err_d;
        end
    end

    assign rd_busy  = (state_q == ST_PEND);
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign wr_err   = wr_err_q;

endmodule

// File: tb/tb_mem_weight_bank_mc.sv
// Scoreboard bench for mem_weight_bank_mc: a 4-bank default build and a
// 3-bank build (for out-of-range bank writes). Stimulus pushes expected read
// data plus the cycle it must appear in; a negedge monitor pops and compares.
module tb_mem_weight_bank_mc;

    typedef struct {
        logic [35:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          cyc = 0;

    // 4-bank build
    logic        rd_req = 1'b0;
    logic [10:0] rd_addr = 11'd0;
    logic        rd_busy;
    logic        rd_valid;
    logic [35:0] rd_data;
    logic        spi_wen = 1'b0;
    logic [15:0] spi_addr = 16'd0;
    logic [31:0] spi_data = 32'd0;
    logic        wr_err;
    logic        err_clr = 1'b0;

    // 3-bank build, 16 rows
    logic        b_rd_req = 1'b0;
    logic [3:0]  b_rd_addr = 4'd0;
    logic        b_rd_busy;
    logic        b_rd_valid;
    logic [26:0] b_rd_data;
    logic        b_wen = 1'b0;
    logic [15:0] b_saddr = 16'd0;
    logic [31:0] b_sdata = 32'd0;
    logic        b_wr_err;
    logic        b_err_clr = 1'b0;

    exp_t        q[$];
    exp_t        qb[$];
    exp_t        mon_e;
    logic        exp_busy = 1'b0;
    logic        exp_err_b = 1'b0;
    logic        final_chk = 1'b0;
    int          n_chk = 0;
    int          n_fail = 0;

    mem_weight_bank_mc dut (
        .clk(clk), .rst_n(rst_n), .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_busy(rd_busy), .rd_valid(rd_valid), .rd_data(rd_data),
        .spi_wen_sync(spi_wen), .SPI_ADDR(spi_addr), .SPI_DATA(spi_data),
        .wr_err(wr_err), .err_clr(err_clr)
    );

    mem_weight_bank_mc #(.NUM_BANKS(3), .DEPTH(16), .WEIGHT_WIDTH(9), .SPI_ADDR_WIDTH(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .rd_req(b_rd_req), .rd_addr(b_rd_addr),
        .rd_busy(b_rd_busy), .rd_valid(b_rd_valid), .rd_data(b_rd_data),
        .spi_wen_sync(b_wen), .SPI_ADDR(b_saddr), .SPI_DATA(b_sdata),
        .wr_err(b_wr_err), .err_clr(b_err_clr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_chk = n_chk + 1;
        if (act !== exp_v) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: actual %0h, required %0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every rd_valid and checks status outputs
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_rd_valid", 64'(rd_valid), 64'd0);
            chk("rst_rd_data", 64'(rd_data), 64'd0);
            chk("rst_rd_busy", 64'(rd_busy), 64'd0);
            chk("rst_wr_err", 64'(wr_err), 64'd0);
            chk("rst_b_wr_err", 64'(b_wr_err), 64'd0);
            chk("rst_b_rd_valid", 64'(b_rd_valid), 64'd0);
        end else begin
            chk("rd_busy", 64'(rd_busy), 64'(exp_busy));
            chk("wr_err", 64'(wr_err), 64'd0);
            chk("b_wr_err", 64'(b_wr_err), 64'(exp_err_b));
            chk("b_rd_busy", 64'(b_rd_busy), 64'd0);
            if (rd_valid !== 1'b0) begin
                if (q.size() == 0) begin
                    chk("rd_unexpected_valid", 64'(rd_valid), 64'd0);
                end else begin
                    mon_e = q.pop_front();
                    chk("rd_data", 64'(rd_data), 64'(mon_e.data));
                    chk("rd_cycle", 64'(cyc), 64'(mon_e.cyc));
                end
            end
            if (b_rd_valid !== 1'b0) begin
                if (qb.size() == 0) begin
                    chk("b_rd_unexpected_valid", 64'(b_rd_valid), 64'd0);
                end else begin
                    mon_e = qb.pop_front();
                    chk("b_rd_data", 64'({9'd0, b_rd_data}), 64'(mon_e.data));
                    chk("b_rd_cycle", 64'(cyc), 64'(mon_e.cyc));
                end
            end
        end
        if (final_chk) begin
            chk("sb_drain", 64'(q.size()), 64'd0);
            chk("b_sb_drain", 64'(qb.size()), 64'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_a(input logic [1:0] bank, input logic [10:0] row, input logic [8:0] d);
        spi_wen  = 1'b1;
        spi_addr = {3'b000, bank, row};
        spi_data = {23'd0, d};
        tick();
        spi_wen  = 1'b0;
    endtask

    task automatic rd_a(input logic [10:0] row, input logic [35:0] d);
        rd_req  = 1'b1;
        rd_addr = row;
        q.push_back('{data: d, cyc: cyc + 1});
        tick();
        rd_req  = 1'b0;
    endtask

    task automatic wr_b(input logic [1:0] bank, input logic [3:0] row, input logic [8:0] d);
        b_wen   = 1'b1;
        b_saddr = {10'd0, bank, row};
        b_sdata = {23'd0, d};
        tick();
        b_wen   = 1'b0;
    endtask

    task automatic rd_b(input logic [3:0] row, input logic [26:0] d);
        b_rd_req  = 1'b1;
        b_rd_addr = row;
        qb.push_back('{data: {9'd0, d}, cyc: cyc + 1});
        tick();
        b_rd_req  = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // Row 5 across all banks, read straight after the last write
        wr_a(2'd0, 11'd5, 9'h0FF);
        wr_a(2'd1, 11'd5, 9'h100);
        wr_a(2'd2, 11'd5, 9'h001);
        wr_a(2'd3, 11'd5, 9'h1FF);
        rd_a(11'd5, {9'h1FF, 9'h001, 9'h100, 9'h0FF});
        tick();

        // Rows 0..2, lane b of row r = r*16 + b + 1, then back-to-back reads
        for (int r = 0; r < 3; r++) begin
            for (int b = 0; b < 4; b++) begin
                wr_a(2'(b), 11'(r), 9'(r * 16 + b + 1));
            end
        end
        rd_a(11'd0, {9'h004, 9'h003, 9'h002, 9'h001});
        rd_a(11'd1, {9'h014, 9'h013, 9'h012, 9'h011});
        rd_a(11'd2, {9'h024, 9'h023, 9'h022, 9'h021});
        tick();

        // Collision on row 7 with a same-row write, then two more write cycles
        wr_a(2'd0, 11'd7, 9'h011);
        wr_a(2'd1, 11'd7, 9'h022);
        wr_a(2'd2, 11'd7, 9'h033);
        wr_a(2'd3, 11'd7, 9'h044);
        rd_req   = 1'b1;
        rd_addr  = 11'd7;
        spi_wen  = 1'b1;
        spi_addr = {3'b000, 2'd2, 11'd7};
        spi_data = 32'h0000_0055;
        q.push_back('{data: {9'h044, 9'h055, 9'h022, 9'h011}, cyc: cyc + 4});
        tick();
        exp_busy = 1'b1;
        rd_req   = 1'b0;
        spi_addr = {3'b000, 2'd0, 11'd100};
        spi_data = 32'h0000_00AA;
        tick();
        rd_req   = 1'b1;              // ignored while a read is parked
        rd_addr  = 11'd0;
        spi_addr = {3'b000, 2'd1, 11'd100};
        spi_data = 32'h0000_00BB;
        tick();
        rd_req   = 1'b0;
        spi_wen  = 1'b0;
        tick();
        exp_busy = 1'b0;
        repeat (2) tick();

        // Collision, then reset while the read is parked
        rd_req   = 1'b1;
        rd_addr  = 11'd5;
        spi_wen  = 1'b1;
        spi_addr = {3'b000, 2'd0, 11'd200};
        spi_data = 32'h0000_0123;
        tick();
        rd_req   = 1'b0;
        exp_busy = 1'b1;
        spi_addr = {3'b000, 2'd1, 11'd200};
        spi_data = 32'h0000_00CC;
        @(negedge clk);
        #1;
        rst_n    = 1'b0;
        spi_wen  = 1'b0;
        exp_busy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) tick();
        rd_a(11'd5, {9'h1FF, 9'h001, 9'h100, 9'h0FF});
        rd_a(11'd7, {9'h044, 9'h055, 9'h022, 9'h011});
        tick();

        // Last row and row 0 with junk above the bank field
        for (int b = 0; b < 4; b++) begin
            spi_wen  = 1'b1;
            spi_addr = {3'b111, 2'(b), 11'd2047};
            spi_data = 32'hFFFF_FE00 | 32'(9'h0AA + 9'(b));
            tick();
        end
        spi_addr = {3'b101, 2'd0, 11'd0};
        spi_data = 32'h0000_00EE;
        tick();
        spi_wen = 1'b0;
        rd_a(11'd2047, {9'h0AD, 9'h0AC, 9'h0AB, 9'h0AA});
        rd_a(11'd0, {9'h004, 9'h003, 9'h002, 9'h0EE});
        rd_a(11'd1, {9'h014, 9'h013, 9'h012, 9'h011});
        tick();

        // 3-bank build: bank field 3 must not write and must raise wr_err
        wr_b(2'd0, 4'd3, 9'h031);
        wr_b(2'd1, 4'd3, 9'h032);
        wr_b(2'd2, 4'd3, 9'h033);
        rd_b(4'd3, {9'h033, 9'h032, 9'h031});
        wr_b(2'd3, 4'd3, 9'h1FF);
        exp_err_b = 1'b1;
        rd_b(4'd3, {9'h033, 9'h032, 9'h031});
        tick();
        b_err_clr = 1'b1;
        tick();
        b_err_clr = 1'b0;
        exp_err_b = 1'b0;
        tick();
        b_err_clr = 1'b1;
        wr_b(2'd3, 4'd0, 9'h155);
        b_err_clr = 1'b0;
        exp_err_b = 1'b1;
        repeat (2) tick();
        b_err_clr = 1'b1;
        tick();
        b_err_clr = 1'b0;
        exp_err_b = 1'b0;
        rd_b(4'd3, {9'h033, 9'h032, 9'h031});

        repeat (3) tick();
        final_chk = 1'b1;
        tick();
        final_chk = 1'b0;
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_weight_bank_mc.md
# mem_weight_bank_mc

Multi-bank signed weight memory for the Tsetlin Machine class-sum stage; the parametrised successor of the single-bank weight store. NUM_BANKS independent banks share one row address, so one read returns a full vector of per-class weights in one access. SPI configuration writes go into a single bank/row and take priority over inference reads. A colliding read is deferred by a one-entry pending buffer instead of being dropped.

## Interface
- NUM_BANKS, 4: banks (classes) read in parallel; ≥1.
- DEPTH, 2048: rows per bank; power of two.
- WEIGHT_WIDTH, 9: signed weight width; ≤32.
- SPI_ADDR_WIDTH, 16: SPI address width; ≥ $clog2(DEPTH)+max(1,$clog2(NUM_BANKS)).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rd_req  in  1  read request for rd_addr; sampled each cycle.
- rd_addr  in  $clog2(DEPTH)  row to read.
- rd_busy  out  1  pending read buffered; upstream must not assert rd_req.
- rd_valid  out  1  one-cycle pulse; rd_data updated this cycle.
- rd_data  out  NUM_BANKS*WEIGHT_WIDTH  signed weights; lane b at [b*WEIGHT_WIDTH +: WEIGHT_WIDTH].
- spi_wen_sync  in  1  synchronised SPI write strobe, one cycle per word.
- SPI_ADDR  in  SPI_ADDR_WIDTH  row = [$clog2(DEPTH)-1:0]; bank = next max(1,$clog2(NUM_BANKS)) bits.
- SPI_DATA  in  32  write data; [WEIGHT_WIDTH-1:0] stored.
- wr_err  out  1  sticky: write addressed bank ≥ NUM_BANKS.
- err_clr  in  1  clears wr_err.

## Operation
- Storage: NUM_BANKS arrays of DEPTH×WEIGHT_WIDTH; contents not reset, power-up undefined.
- Write: on spi_wen_sync with bank < NUM_BANKS, row of that bank ← SPI_DATA[WEIGHT_WIDTH-1:0]; other banks untouched. Bank ≥ NUM_BANKS: no array write, wr_err ← 1.
- wr_err: set on bad write, cleared by err_clr; set and clear in the same cycle → stays 1 (set wins).
- Read issue: a read is issued in a cycle with no write when (a) pend_valid=1, pending address, or else (b) rd_req=1, rd_addr.
- Issued read: all banks read at the row; rd_data registered next edge, rd_valid=1 for that cycle only.
- Collision: rd_req=1 and spi_wen_sync=1 with pend_valid=0 → pend_addr ← rd_addr, pend_valid ← 1. Pending read is issued in the first later cycle without a write, then pend_valid ← 0.
- rd_req while pend_valid=1 is ignored; this is a protocol violation, not an error flag.
- Same-row read and write in the same cycle: write wins, and the deferred read returns the new value.
- Control states: IDLE (pend_valid=0), PEND (pend_valid=1). IDLE→PEND on collision; PEND→IDLE on the first no-write cycle; otherwise stay.
- rd_data holds its last value between reads; lanes are not sign-extended (raw WEIGHT_WIDTH two's complement).

## Timing
- Reset (async assert, sync deassert by system): rd_valid=0, rd_data=0, rd_busy=0, pend_valid=0, wr_err=0. A pending read is discarded and no rd_valid follows.
- Read latency: rd_req at edge N with no write → rd_valid high after edge N+1.
- Deferred read: rd_valid appears one cycle after the first write-free cycle. Latency = 1 + number of consecutive write cycles starting at the request cycle.
- rd_busy = pend_valid (registered), high from the cycle after the collision until the pending read is issued.
- Back-to-back reads without writes: one per cycle, rd_valid continuous.
- Write latency: written data is visible to a read issued on the next cycle.

## Test plan
- Reset, then write bank0..3 row 5 with 0x0FF, 0x100, 0x001, 0x1FF; rd_req row 5 → one cycle later rd_valid=1, lanes {0x1FF,0x001,0x100,0x0FF} from lane3 down to lane0.
- Back-to-back rd_req rows 0,1,2 for 3 cycles → rd_valid high 3 consecutive cycles, data in order, rd_busy=0.
- rd_req row 7 with a write to bank2 row 7 = 0x055 in the same cycle, then 2 more write cycles → rd_busy high 3 cycles; rd_valid 4 cycles after request; lane2 = 0x055.
- NUM_BANKS=3 build: write with bank field 3 → no array change (readback unchanged), wr_err=1; err_clr → 0; err_clr coincident with a new bad write → stays 1.
- Collision, then assert rst_n=0 while rd_busy=1 → all outputs 0 immediately; after release no rd_valid; array contents preserved.
- Row DEPTH-1 and row 0 write/read → correct data, no aliasing (upper SPI_ADDR bits above bank field ignored).
